// File: rtl/decode_pkg.sv
// Shared decode definitions: RV32I base opcodes, immediate formats and the
// per-lane decoded-instruction record passed from lane_decode to the stage.
package decode_pkg;

  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  typedef struct packed {
    logic [6:0] opcode;
    logic [2:0] func3;
    logic [6:0] func7;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       uses_rs1;
    logic       uses_rs2;
    logic       writes_rd;
    logic       illegal;
    imm_fmt_e   fmt;
  } decoded_t;

  function automatic logic is_legal(input logic [6:0] opcode);
    return opcode inside {OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR, OPC_BRANCH,
                          OPC_LOAD, OPC_STORE, OPC_OP_IMM, OPC_OP};
  endfunction

  // OP and unknown opcodes both carry no immediate.
  function automatic imm_fmt_e imm_format(input logic [6:0] opcode);
    case (opcode)
      OPC_LUI, OPC_AUIPC:               return IMM_U;
      OPC_JAL:                          return IMM_J;
      OPC_JALR, OPC_LOAD, OPC_OP_IMM:   return IMM_I;
      OPC_BRANCH:                       return IMM_B;
      OPC_STORE:                        return IMM_S;
      default:                          return IMM_NONE;
    endcase
  endfunction

endpackage

// File: rtl/decode_stage_lane.sv
// Combinational decode of one 32-bit instruction slot; an invalid lane
// produces an all-zero record so downstream never sees stale fields.
module lane_decode
  import decode_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [31:0]     instr,
  input  logic            lane_valid,
  output decoded_t        dec,
  output logic [XLEN-1:0] imm
);

  logic     legal;
  imm_fmt_e fmt;
  logic     sign;

  always_comb begin
    dec   = '0;
    imm   = '0;
    legal = is_legal(instr[6:0]);
    fmt   = imm_format(instr[6:0]);
    sign  = instr[31];
    if (lane_valid) begin
      dec.opcode    = instr[6:0];
      dec.func3     = instr[14:12];
      dec.func7     = instr[31:25];
      dec.rs1       = instr[19:15];
      dec.rs2       = instr[24:20];
      dec.illegal   = !legal;
      dec.fmt       = fmt;
      dec.uses_rs1  = legal && (instr[6:0] inside {OPC_JALR, OPC_BRANCH, OPC_LOAD,
                                                    OPC_STORE, OPC_OP_IMM, OPC_OP});
      dec.uses_rs2  = legal && (instr[6:0] inside {OPC_BRANCH, OPC_STORE, OPC_OP});
      // x0 is never a real destination, so a zero rd field also clears writes_rd.
      dec.writes_rd = legal && !(instr[6:0] inside {OPC_STORE, OPC_BRANCH})
                      && (instr[11:7] != 5'd0);
      dec.rd        = dec.writes_rd ? instr[11:7] : 5'd0;
      case (fmt)
        IMM_I:   imm = {{(XLEN-11){sign}}, instr[30:20]};
        IMM_S:   imm = {{(XLEN-11){sign}}, instr[30:25], instr[11:7]};
        IMM_B:   imm = {{(XLEN-12){sign}}, instr[7], instr[30:25], instr[11:8], 1'b0};
        IMM_U:   imm = {{(XLEN-31){sign}}, instr[30:12], 12'd0};
        IMM_J:   imm = {{(XLEN-20){sign}}, instr[19:12], instr[20], instr[30:21], 1'b0};
        default: imm = '0;
      endcase
    end
  end

endmodule

// File: rtl/decode_stage.sv
// Multi-lane RV32I decode stage: per-lane combinational decode feeding a
// registered output slot backed by one skid slot.
module decode_stage
  import decode_pkg::*;
#(
  parameter int LANES = 2,
  parameter int XLEN  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES*32-1:0]   in_instr,
  input  logic [LANES-1:0]      in_lane_valid,
  input  logic [XLEN-1:0]       in_pc,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [LANES-1:0]      out_lane_valid,
  output logic [LANES*7-1:0]    out_opcode,
  output logic [LANES*3-1:0]    out_func3,
  output logic [LANES*7-1:0]    out_func7,
  output logic [LANES*5-1:0]    out_rs1,
  output logic [LANES*5-1:0]    out_rs2,
  output logic [LANES*5-1:0]    out_rd,
  output logic [LANES*XLEN-1:0] out_imm,
  output logic [LANES*XLEN-1:0] out_pc,
  output logic [LANES-1:0]      out_uses_rs1,
  output logic [LANES-1:0]      out_uses_rs2,
  output logic [LANES-1:0]      out_writes_rd,
  output logic [LANES-1:0]      out_illegal
);

  // Handshake: a bundle moves on either side only in a cycle where valid and
  // ready are both high; out_valid and all out_* hold until out_ready, and
  // in_ready is a pure register (skid empty) with no path from out_ready.

  decoded_t [LANES-1:0]            dec_d, dec_out, dec_skid;
  logic     [LANES-1:0][XLEN-1:0]  imm_d, imm_out, imm_skid;
  logic     [LANES-1:0][XLEN-1:0]  pc_d, pc_out, pc_skid;
  logic     [LANES-1:0]            mask_out, mask_skid;
  logic                            skid_valid;
  logic                            accept;

  assign in_ready = !skid_valid;
  // An all-invalid bundle is consumed but never produces an output.
  assign accept   = in_valid && !skid_valid && (|in_lane_valid);

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    lane_decode #(.XLEN(XLEN)) u_lane (
      .instr      (in_instr[32*i +: 32]),
      .lane_valid (in_lane_valid[i]),
      .dec        (dec_d[i]),
      .imm        (imm_d[i])
    );
    assign pc_d[i] = in_lane_valid[i] ? (in_pc + XLEN'(4 * i)) : '0;

    assign out_opcode[7*i +: 7]       = dec_out[i].opcode;
    assign out_func3[3*i +: 3]        = dec_out[i].func3;
    assign out_func7[7*i +: 7]        = dec_out[i].func7;
    assign out_rs1[5*i +: 5]          = dec_out[i].rs1;
    assign out_rs2[5*i +: 5]          = dec_out[i].rs2;
    assign out_rd[5*i +: 5]           = dec_out[i].rd;
    assign out_uses_rs1[i]            = dec_out[i].uses_rs1;
    assign out_uses_rs2[i]            = dec_out[i].uses_rs2;
    assign out_writes_rd[i]           = dec_out[i].writes_rd;
    assign out_illegal[i]             = dec_out[i].illegal;
    assign out_imm[XLEN*i +: XLEN]    = imm_out[i];
    assign out_pc[XLEN*i +: XLEN]     = pc_out[i];
  end

  assign out_lane_valid = mask_out;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      dec_out    <= '0;
      imm_out    <= '0;
      pc_out     <= '0;
      mask_out   <= '0;
      dec_skid   <= '0;
      imm_skid   <= '0;
      pc_skid    <= '0;
      mask_skid  <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (!out_valid || out_ready) begin
      // Output slot is free this edge; the skid slot has priority to keep order.
      if (skid_valid) begin
        dec_out    <= dec_skid;
        imm_out    <= imm_skid;
        pc_out     <= pc_skid;
        mask_out   <= mask_skid;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        out_valid <= accept;
        if (accept) begin
          dec_out  <= dec_d;
          imm_out  <= imm_d;
          pc_out   <= pc_d;
          mask_out <= in_lane_valid;
        end
      end
    end else if (accept) begin
      dec_skid   <= dec_d;
      imm_skid   <= imm_d;
      pc_skid    <= pc_d;
      mask_skid  <= in_lane_valid;
      skid_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (LANES=2, XLEN=32): hand-decoded vectors,
// stall/skid ordering through an expected queue, flush and async reset.
module tb_decode_stage;

  localparam int LANES = 2;
  localparam int XLEN  = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic                  flush;
  logic                  in_valid;
  logic                  in_ready;
  logic [LANES*32-1:0]   in_instr;
  logic [LANES-1:0]      in_lane_valid;
  logic [XLEN-1:0]       in_pc;
  logic                  out_valid;
  logic                  out_ready;
  logic [LANES-1:0]      out_lane_valid;
  logic [LANES*7-1:0]    out_opcode;
  logic [LANES*3-1:0]    out_func3;
  logic [LANES*7-1:0]    out_func7;
  logic [LANES*5-1:0]    out_rs1;
  logic [LANES*5-1:0]    out_rs2;
  logic [LANES*5-1:0]    out_rd;
  logic [LANES*XLEN-1:0] out_imm;
  logic [LANES*XLEN-1:0] out_pc;
  logic [LANES-1:0]      out_uses_rs1;
  logic [LANES-1:0]      out_uses_rs2;
  logic [LANES-1:0]      out_writes_rd;
  logic [LANES-1:0]      out_illegal;

  int n_cmp = 0;
  int n_err = 0;
  logic [XLEN-1:0] exp_q[$];

  decode_stage #(.LANES(LANES), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
    .in_lane_valid(in_lane_valid), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_lane_valid(out_lane_valid),
    .out_opcode(out_opcode), .out_func3(out_func3), .out_func7(out_func7),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd),
    .out_imm(out_imm), .out_pc(out_pc),
    .out_uses_rs1(out_uses_rs1), .out_uses_rs2(out_uses_rs2),
    .out_writes_rd(out_writes_rd), .out_illegal(out_illegal)
  );

  // Clock / reset
  always #5 clk = ~clk;

  // Checking
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Drivers: everything changes 1ns after a rising edge, checks happen there too.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] i1, input logic [31:0] i0,
                       input logic [1:0] mask, input logic [XLEN-1:0] pc);
    in_valid      = 1'b1;
    in_instr      = {i1, i0};
    in_lane_valid = mask;
    in_pc         = pc;
  endtask

  task automatic idle();
    in_valid      = 1'b0;
    in_instr      = '0;
    in_lane_valid = '0;
    in_pc         = '0;
  endtask

  localparam logic [31:0] ADDI_X1_10 = 32'h00A00093;
  localparam logic [31:0] BEQ_8      = 32'h00B50463;
  localparam logic [31:0] SW_M4      = 32'hFE112E23;
  localparam logic [31:0] BAD_OPC    = 32'h0000007F;
  localparam logic [31:0] JAL_8      = 32'h008000EF;

  initial begin
    rst = 1'b1; flush = 1'b0; out_ready = 1'b0;
    idle();
    #2;
    check("reset_out_valid", out_valid, 0);
    check("reset_in_ready", in_ready, 1);
    check("reset_lane_mask", out_lane_valid, 0);
    check("reset_imm", out_imm, 0);
    step(); step();
    rst = 1'b0;
    step();

    // ADDI in lane 0, BEQ in lane 1
    out_ready = 1'b1;
    drive(BEQ_8, ADDI_X1_10, 2'b11, 32'h100);
    step();
    idle();
    check("t1_out_valid", out_valid, 1);
    check("t1_mask", out_lane_valid, 2'b11);
    check("t1_l0_rd", out_rd[4:0], 1);
    check("t1_l0_imm", out_imm[31:0], 10);
    check("t1_l0_pc", out_pc[31:0], 32'h100);
    check("t1_l0_writes_rd", out_writes_rd[0], 1);
    check("t1_l0_uses_rs2", out_uses_rs2[0], 0);
    check("t1_l1_rd", out_rd[9:5], 0);
    check("t1_l1_imm", out_imm[63:32], 8);
    check("t1_l1_uses_rs2", out_uses_rs2[1], 1);
    check("t1_l1_rs1", out_rs1[9:5], 10);
    check("t1_l1_rs2", out_rs2[9:5], 11);
    check("t1_l1_pc", out_pc[63:32], 32'h104);

    // Store in lane 0 only; lane 1 must be all zero
    drive(ADDI_X1_10, SW_M4, 2'b01, 32'h400);
    step();
    idle();
    check("t2_l0_rd", out_rd[4:0], 0);
    check("t2_l0_writes_rd", out_writes_rd[0], 0);
    check("t2_l0_imm", out_imm[31:0], 32'hFFFFFFFC);
    check("t2_l0_rs1", out_rs1[4:0], 2);
    check("t2_l0_rs2", out_rs2[4:0], 1);
    check("t2_l0_func3", out_func3[2:0], 3'b010);
    check("t2_mask", out_lane_valid, 2'b01);
    check("t2_l1_zero", {out_imm[63:32], out_pc[63:32], out_opcode[13:7], out_rs1[9:5]}, 0);

    // Illegal opcode in lane 1 with PC wrap
    drive(BAD_OPC, ADDI_X1_10, 2'b11, 32'hFFFFFFFC);
    step();
    idle();
    check("t3_l1_illegal", out_illegal[1], 1);
    check("t3_l1_rd", out_rd[9:5], 0);
    check("t3_l1_pc", out_pc[63:32], 32'h0);
    check("t3_l1_uses_rs1", out_uses_rs1[1], 0);
    check("t3_l1_imm", out_imm[63:32], 0);
    check("t3_l0_pc", out_pc[31:0], 32'hFFFFFFFC);
    check("t3_l0_illegal", out_illegal[0], 0);

    // Stall for three cycles while A then B are fed
    step();
    out_ready = 1'b0;
    drive(32'h0, ADDI_X1_10, 2'b01, 32'h200);
    exp_q.push_back(32'h200);
    step();
    check("t4_a_in_ready", in_ready, 1);
    check("t4_a_pc", out_pc[31:0], 32'h200);
    drive(32'h0, ADDI_X1_10, 2'b01, 32'h300);
    exp_q.push_back(32'h300);
    step();
    idle();
    check("t4_b_in_ready", in_ready, 0);
    check("t4_b_hold_pc", out_pc[31:0], 32'h200);
    step();
    check("t4_hold_valid", out_valid, 1);
    check("t4_hold_pc", out_pc[31:0], 32'h200);
    out_ready = 1'b1;
    for (int c = 0; c < 8; c++) begin
      if (out_valid) begin
        if (exp_q.size() == 0) check("t4_extra_bundle", out_pc[31:0], 0);
        else check("t4_order_pc", out_pc[31:0], exp_q.pop_front());
      end
      step();
    end
    check("t4_queue_drained", exp_q.size(), 0);
    check("t4_in_ready_back", in_ready, 1);

    // Flush with both slots full and a bundle presented
    out_ready = 1'b0;
    drive(32'h0, ADDI_X1_10, 2'b01, 32'h500);
    step();
    drive(32'h0, ADDI_X1_10, 2'b01, 32'h600);
    step();
    check("t5_full_in_ready", in_ready, 0);
    drive(32'h0, ADDI_X1_10, 2'b01, 32'h700);
    flush = 1'b1;
    step();
    flush = 1'b0;
    idle();
    out_ready = 1'b1;
    check("t5_flush_out_valid", out_valid, 0);
    check("t5_flush_in_ready", in_ready, 1);
    step();
    check("t5_no_emit", out_valid, 0);

    // Valid bundle with no valid lanes is swallowed
    drive(ADDI_X1_10, ADDI_X1_10, 2'b00, 32'h800);
    step();
    idle();
    check("t6_empty_mask_dropped", out_valid, 0);
    check("t6_in_ready", in_ready, 1);

    // Asynchronous reset in the middle of a stall
    out_ready = 1'b0;
    drive(32'h0, ADDI_X1_10, 2'b01, 32'h900);
    step();
    drive(32'h0, ADDI_X1_10, 2'b01, 32'hA00);
    step();
    idle();
    #3;
    rst = 1'b1;
    #1;
    check("t7_rst_out_valid", out_valid, 0);
    check("t7_rst_in_ready", in_ready, 1);
    check("t7_rst_mask", out_lane_valid, 0);
    check("t7_rst_pc", out_pc, 0);
    #1;
    rst = 1'b0;
    step();
    out_ready = 1'b1;
    drive(32'h0, JAL_8, 2'b01, 32'h1000);
    step();
    idle();
    check("t7_jal_valid", out_valid, 1);
    check("t7_jal_rd", out_rd[4:0], 1);
    check("t7_jal_imm", out_imm[31:0], 8);
    check("t7_jal_uses_rs1", out_uses_rs1[0], 0);
    check("t7_jal_pc", out_pc[31:0], 32'h1000);
    step();
    check("t7_single_emit", out_valid, 0);

    // Report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
